// File: rtl/reg_file_sequencer.sv
// reg_file_sequencer: multi-cycle control unit for the 16x8 register-file
// datapath. It accepts one 16-bit instruction over a valid/ready handshake and
// walks it through IDLE -> DECODE -> (READ -> EXEC ->) WRITE. It drives the
// read selects, the ALU opcode, the write-data source and the write port.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   instr_valid, instr       instruction handshake input
//                            ([15:12] op, [11:8] rd, [7:4] ra, [3:0] rb, [7:0] imm)
//   resume                   leave HALTED
//   instr_ready              combinational: (state==IDLE) & ~rst
//   SBA, SBB                 read-port A/B selects (held until the next READ)
//   select, LE               write-port select and write enable
//   wr_src                   0 ALU, 1 immediate, 2 external In, 3 port A (MOV)
//   imm                      immediate value
//   alu_op                   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
//   done, illegal            one-cycle retire / undefined-opcode pulses
//   halted                   high while in HALTED
//   instr_count              retired-instruction counter (wraps)
//
// Configuration macro: REG0_ZERO_EN -- when defined, writes to r0 are
// suppressed (LE stays low) while the instruction still retires normally.

module reg_file_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    input  logic              resume,
    output logic              instr_ready,
    output logic [REG_AW-1:0] SBA,
    output logic [REG_AW-1:0] SBB,
    output logic [REG_AW-1:0] select,
    output logic              LE,
    output logic [1:0]        wr_src,
    output logic [DATA_W-1:0] imm,
    output logic [2:0]        alu_op,
    output logic              done,
    output logic              illegal,
    output logic              halted,
    output logic [15:0]       instr_count
);

    localparam int unsigned CNT_W = 16;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_IN   = 4'd2;
    localparam logic [3:0] OP_MOV  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd9;

`ifdef REG0_ZERO_EN
    localparam bit REG0_ZERO = 1'b1;
`else
    localparam bit REG0_ZERO = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_READ, S_EXEC, S_WRITE, S_HALTED
    } state_t;

    state_t      state;
    logic [15:0] instr_q;

    // Decoded fields of the latched instruction
    logic [3:0] op_c, rd_c, ra_c, rb_c;
    logic       wr_en_c;
    logic       in_illegal_c;

    assign op_c = instr_q[15:12];
    assign rd_c = instr_q[11:8];
    assign ra_c = instr_q[7:4];
    assign rb_c = instr_q[3:0];

    // Write-port enable for the current destination (r0 may be hard-wired zero)
    assign wr_en_c = !(REG0_ZERO && (rd_c == 4'd0));

    // Opcodes 10..15 are undefined; checked on the incoming word at handshake
    assign in_illegal_c = (instr[15:12] > OP_HALT);

    assign instr_ready = (state == S_IDLE) && !rst;

    // Sequencer state and registered Moore outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            instr_q     <= '0;
            SBA         <= '0;
            SBB         <= '0;
            select      <= '0;
            LE          <= 1'b0;
            wr_src      <= 2'd0;
            imm         <= '0;
            alu_op      <= 3'd0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            LE      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state   <= S_DECODE;
                        // NOP/HALT/illegal pulse their outcome during DECODE
                        if (instr[15:12] == OP_NOP || instr[15:12] == OP_HALT) begin
                            done        <= 1'b1;
                            instr_count <= instr_count + CNT_W'(1);
                        end else if (in_illegal_c) begin
                            illegal <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    imm <= DATA_W'(instr_q[7:0]);
                    case (op_c)
                        OP_LDI, OP_IN: begin
                            wr_src      <= (op_c == OP_LDI) ? 2'd1 : 2'd2;
                            select      <= REG_AW'(rd_c);
                            LE          <= wr_en_c;
                            done        <= 1'b1;
                            instr_count <= instr_count + CNT_W'(1);
                            state       <= S_WRITE;
                        end
                        OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            SBA    <= REG_AW'(ra_c);
                            SBB    <= REG_AW'(rb_c);
                            wr_src <= (op_c == OP_MOV) ? 2'd3 : 2'd0;
                            // ALU opcodes 4..8 map onto alu_op 0..4
                            alu_op <= (op_c == OP_MOV) ? 3'd0 : 3'(op_c - OP_ADD);
                            state  <= S_READ;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
                S_READ: state <= S_EXEC;
                S_EXEC: begin
                    select      <= REG_AW'(rd_c);
                    LE          <= wr_en_c;
                    done        <= 1'b1;
                    instr_count <= instr_count + CNT_W'(1);
                    state       <= S_WRITE;
                end
                S_WRITE: state <= S_IDLE;
                S_HALTED: begin
                    if (resume) begin
                        halted <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Scoreboard bench for reg_file_sequencer: directed instructions push their
// expected retirement record; a negedge monitor pops and compares on each
// done/illegal pulse.

module tb_reg_file_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        resume;
    logic        instr_ready;
    logic [3:0]  SBA, SBB, select;
    logic        LE;
    logic [1:0]  wr_src;
    logic [7:0]  imm;
    logic [2:0]  alu_op;
    logic        done, illegal, halted;
    logic [15:0] instr_count;

    reg_file_sequencer #(.DATA_W(8), .REG_AW(4)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .resume(resume), .instr_ready(instr_ready), .SBA(SBA), .SBB(SBB),
        .select(select), .LE(LE), .wr_src(wr_src), .imm(imm), .alu_op(alu_op),
        .done(done), .illegal(illegal), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  kind;      // 1 done, 2 illegal
        int  cyc;       // cycle index where the pulse is expected
        bit  wr;        // instruction goes through WRITE
        bit  le;
        int  sel;
        int  src;
        int  immv;
        int  op;        // -1 = don't care
        bit  rdchk;
        int  sba;
        int  sbb;
        int  cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;

`ifdef REG0_ZERO_EN
    localparam bit R0_LE = 1'b0;
`else
    localparam bit R0_LE = 1'b1;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compare each retirement/illegal pulse against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done && illegal) chk("done_and_illegal", 1, 0);
            if (LE && !done) chk("le_without_done", 1, 0);
            if (done || illegal) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_done", int'(done), int'(e.kind == 1));
                    chk("pulse_illegal", int'(illegal), int'(e.kind == 2));
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("count", int'(instr_count), e.cnt);
                    chk("le", int'(LE), int'(e.wr && e.le));
                    if (e.wr) begin
                        chk("select", int'(select), e.sel);
                        chk("wr_src", int'(wr_src), e.src);
                        if (e.src == 1) chk("imm", int'(imm), e.immv);
                    end
                    if (e.op >= 0) chk("alu_op", int'(alu_op), e.op);
                    if (e.rdchk) begin
                        chk("sba", int'(SBA), e.sba);
                        chk("sbb", int'(SBB), e.sbb);
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] ins, input bit wt, input int kind, input int lat,
                        input bit wr, input bit le, input int sel, input int src,
                        input int immv, input int op, input bit rdchk,
                        input int sba, input int sbb);
        exp_t e;
        int n;
        @(negedge clk);
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        if (kind == 1) exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        e.kind = kind; e.cyc = cyc + lat - 1; e.wr = wr; e.le = le; e.sel = sel;
        e.src = src; e.immv = immv; e.op = op; e.rdchk = rdchk; e.sba = sba;
        e.sbb = sbb; e.cnt = exp_cnt;
        sb.push_back(e);
        if (wt) begin
            for (int i = 1; i <= lat; i++) begin
                @(negedge clk);
                chk("busy_ready", int'(instr_ready), 0);
            end
            if (ins[15:12] != 4'd9) begin
                @(negedge clk);
                chk("ready_again", int'(instr_ready), 1);
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, int'(instr_ready), 0);
        chk({tag, "_le"}, int'(LE), 0);
        chk({tag, "_sba_sbb_sel"}, int'({SBA, SBB, select}), 0);
        chk({tag, "_src_imm_op"}, int'({wr_src, imm, alu_op}), 0);
        chk({tag, "_pulses"}, int'({done, illegal, halted}), 0);
        chk({tag, "_count"}, int'(instr_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; resume = 1'b0;
        #1;
        chk_reset_vals("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", int'(instr_ready), 1);

        //   ins       wt kind lat wr le     sel src imm   op rd sba sbb
        send(16'h135A, 1, 1, 2, 1, 1,     3, 1, 8'h5A, -1, 0, 0, 0); // LDI r3,5A
        send(16'h1211, 1, 1, 2, 1, 1,     2, 1, 8'h11, -1, 0, 0, 0); // LDI r2,11
        send(16'h4432, 1, 1, 4, 1, 1,     4, 0, 0,      0, 1, 3, 2); // ADD r4,r3,r2
        send(16'h5543, 1, 1, 4, 1, 1,     5, 0, 0,      1, 1, 4, 3); // SUB
        send(16'h6612, 1, 1, 4, 1, 1,     6, 0, 0,      2, 1, 1, 2); // AND
        send(16'h7712, 1, 1, 4, 1, 1,     7, 0, 0,      3, 1, 1, 2); // OR
        send(16'h8812, 1, 1, 4, 1, 1,     8, 0, 0,      4, 1, 1, 2); // XOR
        send(16'h3930, 1, 1, 4, 1, 1,     9, 3, 0,     -1, 1, 3, 0); // MOV r9,r3
        send(16'h2700, 1, 1, 2, 1, 1,     7, 2, 0,     -1, 0, 0, 0); // IN r7
        send(16'h0000, 1, 1, 1, 0, 0,     0, 0, 0,     -1, 0, 0, 0); // NOP
        send(16'hC123, 1, 2, 1, 0, 0,     0, 0, 0,     -1, 0, 0, 0); // illegal 0xC
        send(16'hF000, 1, 2, 1, 0, 0,     0, 0, 0,     -1, 0, 0, 0); // illegal 0xF
        chk("count_after_illegal", int'(instr_count), 10);

        // HALT with resume raised during DECODE (must be ignored)
        send(16'h9000, 0, 1, 1, 0, 0,     0, 0, 0,     -1, 0, 0, 0);
        resume = 1'b1;
        @(posedge clk);
        #1;
        resume = 1'b0;
        instr = 16'h1111;
        instr_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("halted", int'(halted), 1);
            chk("halted_ready", int'(instr_ready), 0);
        end
        instr_valid = 1'b0;
        resume = 1'b1;
        @(posedge clk);
        #1;
        resume = 1'b0;
        @(negedge clk);
        chk("resumed_ready", int'(instr_ready), 1);
        chk("resumed_halted", int'(halted), 0);

        // Reset during EXEC of an XOR discards it
        send(16'h8512, 0, 1, 4, 1, 1,     5, 0, 0,      4, 1, 1, 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_exec");
        void'(sb.pop_back());
        exp_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(16'h8A12, 1, 1, 4, 1, 1,    10, 0, 0,      4, 1, 1, 2); // XOR r10

        // Reset during WRITE drops LE asynchronously
        send(16'h1833, 0, 1, 2, 1, 1,     8, 1, 8'h33, -1, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("le_before_rst", int'(LE), 1);
        rst = 1'b1;
        #1;
        chk("le_async_drop", int'(LE), 0);
        chk("done_async_drop", int'(done), 0);
        void'(sb.pop_back());
        exp_cnt = 0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Write to r0
        send(16'h10FF, 1, 1, 2, 1, R0_LE, 0, 1, 8'hFF, -1, 0, 0, 0); // LDI r0,FF
        send(16'h4011, 1, 1, 4, 1, R0_LE, 0, 0, 0,      0, 1, 1, 1); // ADD r0,r1,r1

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
